// File: rtl/alu_bist_pkg.sv
// Shared types, widths, tap positions and step functions for the ALU BIST controller.
// The LFSR and MISR next-state maths live here so the controller and the MISR agree on it.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LFSR_W = 19;
  localparam int MISR_W = 8;
  localparam int CNT_W  = 16;

  localparam int LFSR_TAP0 = 18;
  localparam int LFSR_TAP1 = 17;
  localparam int LFSR_TAP2 = 16;
  localparam int LFSR_TAP3 = 13;

  // Feedback taps at misr bits 7, 5, 4 and 3.
  localparam logic [MISR_W-1:0] MISR_TAPS = 8'b1011_1000;

  localparam int A_MSB   = 18;
  localparam int A_LSB   = 11;
  localparam int B_MSB   = 10;
  localparam int B_LSB   = 3;
  localparam int CMD_MSB = 2;
  localparam int CMD_LSB = 0;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], l[LFSR_TAP0] ^ l[LFSR_TAP1] ^ l[LFSR_TAP2] ^ l[LFSR_TAP3]};
  endfunction

  function automatic logic tap_parity(input logic [MISR_W-1:0] m);
    return ^(m & MISR_TAPS);
  endfunction

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                  input logic [MISR_W-1:0] d);
    return {m[MISR_W-2:0], tap_parity(m)} ^ d;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// 8-bit multiple-input signature register with synchronous clear and enable.
// The next value is exported so the controller can judge the final signature on the closing edge.
module bist_misr
  import alu_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [MISR_W-1:0] d,
  output logic [MISR_W-1:0] sig,
  output logic [MISR_W-1:0] nxt
);

  logic [MISR_W-1:0] sig_r;

  assign nxt = misr_step(sig_r, d);
  assign sig = sig_r;

  // Signature register: clear wins over compaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_r <= 8'h00;
    end else if (clr) begin
      sig_r <= 8'h00;
    end else if (en) begin
      sig_r <= nxt;
    end
  end

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST controller for the 8-bit ALU: LFSR pattern source, MISR response compactor
// and a pass/fail verdict against a golden signature after N_PATTERNS patterns.
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int                N_PATTERNS = 255,
  parameter logic [LFSR_W-1:0] SEED       = 19'h00001,
  parameter logic [MISR_W-1:0] GOLDEN     = 8'h00
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic [7:0]        A,
  output logic [7:0]        B,
  output logic [2:0]        CMD,
  input  logic [MISR_W-1:0] S,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [MISR_W-1:0] SIG
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PATTERNS - 1);

  state_t            state_r;
  logic [LFSR_W-1:0] lfsr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              busy_r;
  logic              done_r;
  logic              pass_r;
  logic              load_s;
  logic              en_s;
  logic [MISR_W-1:0] misr_sig_s;
  logic [MISR_W-1:0] misr_nxt_s;

  // MISR control: START only loads outside RUN, compaction only in RUN.
  always_comb begin
    load_s = 1'b0;
    en_s   = 1'b0;
    if (state_r == alu_bist_pkg::RUN) begin
      en_s = 1'b1;
    end else begin
      load_s = START;
    end
  end

  bist_misr u_misr (
    .clk (CLK),
    .rst (RST),
    .clr (load_s),
    .en  (en_s),
    .d   (S),
    .sig (misr_sig_s),
    .nxt (misr_nxt_s)
  );

  // Run sequencer with state-decoded, registered BUSY/DONE/PASS.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= alu_bist_pkg::IDLE;
      lfsr_r  <= SEED;
      cnt_r   <= 16'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      case (state_r)
        alu_bist_pkg::IDLE, alu_bist_pkg::DONE: begin
          if (START) begin
            state_r <= alu_bist_pkg::RUN;
            lfsr_r  <= SEED;
            cnt_r   <= 16'd0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
          end
        end
        alu_bist_pkg::RUN: begin
          cnt_r <= cnt_r + 16'd1;
          if (cnt_r == LAST) begin
            state_r <= alu_bist_pkg::DONE;
            lfsr_r  <= SEED;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (misr_nxt_s == GOLDEN);
          end else begin
            lfsr_r <= lfsr_step(lfsr_r);
          end
        end
        default: begin
          state_r <= alu_bist_pkg::IDLE;
          lfsr_r  <= SEED;
          cnt_r   <= 16'd0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

  assign A    = lfsr_r[A_MSB:A_LSB];
  assign B    = lfsr_r[B_MSB:B_LSB];
  assign CMD  = lfsr_r[CMD_MSB:CMD_LSB];
  assign BUSY = busy_r;
  assign DONE = done_r;
  assign PASS = pass_r;
  assign SIG  = misr_sig_s;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Directed bench for alu_bist_ctrl: default run, 2-pattern runs, START/RST during RUN,
// and a real-ALU run against a bench-computed golden signature with a stuck-at fault.
module tb_alu_bist_ctrl;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] c);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return {a[6:0], 1'b0};
      default: return {1'b0, a[7:1]};
    endcase
  endfunction

  function automatic logic [7:0] model_sig(input int n, input logic stuck);
    logic [18:0] l;
    logic [7:0]  m;
    logic [7:0]  s;
    l = 19'h00001;
    m = 8'h00;
    for (int k = 0; k < n; k++) begin
      s = alu_f(l[18:11], l[10:3], l[2:0]);
      if (stuck) s[3] = 1'b0;
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ s;
      l = {l[17:0], l[18] ^ l[17] ^ l[16] ^ l[13]};
    end
    return m;
  endfunction

  localparam logic [7:0] GOLD_ALU   = model_sig(255, 1'b0);
  localparam logic [7:0] GOLD_STUCK = model_sig(255, 1'b1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       start_def = 1'b0;
  logic       start_n2 = 1'b0;
  logic       start_alu = 1'b0;
  logic       fault = 1'b0;
  logic [7:0] s_def = 8'h00;
  logic [7:0] s_alu;

  logic [7:0] a_def, b_def, sig_def, a_n2a, b_n2a, sig_n2a, a_n2b, b_n2b, sig_n2b;
  logic [7:0] a_alu, b_alu, sig_alu;
  logic [2:0] cmd_def, cmd_n2a, cmd_n2b, cmd_alu;
  logic busy_def, done_def, pass_def, busy_n2a, done_n2a, pass_n2a;
  logic busy_n2b, done_n2b, pass_n2b, busy_alu, done_alu, pass_alu;

  int checks = 0;
  int errors = 0;

  always_comb begin
    s_alu = alu_f(a_alu, b_alu, cmd_alu);
    if (fault) s_alu[3] = 1'b0;
  end

  alu_bist_ctrl u_def (
    .CLK(clk), .RST(rst), .START(start_def), .A(a_def), .B(b_def), .CMD(cmd_def),
    .S(s_def), .BUSY(busy_def), .DONE(done_def), .PASS(pass_def), .SIG(sig_def));

  alu_bist_ctrl #(.N_PATTERNS(2), .GOLDEN(8'h03)) u_n2a (
    .CLK(clk), .RST(rst), .START(start_n2), .A(a_n2a), .B(b_n2a), .CMD(cmd_n2a),
    .S(8'h01), .BUSY(busy_n2a), .DONE(done_n2a), .PASS(pass_n2a), .SIG(sig_n2a));

  alu_bist_ctrl #(.N_PATTERNS(2), .GOLDEN(8'h00)) u_n2b (
    .CLK(clk), .RST(rst), .START(start_n2), .A(a_n2b), .B(b_n2b), .CMD(cmd_n2b),
    .S(8'h01), .BUSY(busy_n2b), .DONE(done_n2b), .PASS(pass_n2b), .SIG(sig_n2b));

  alu_bist_ctrl #(.GOLDEN(GOLD_ALU)) u_alu (
    .CLK(clk), .RST(rst), .START(start_alu), .A(a_alu), .B(b_alu), .CMD(cmd_alu),
    .S(s_alu), .BUSY(busy_alu), .DONE(done_alu), .PASS(pass_alu), .SIG(sig_alu));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({a_def, b_def, cmd_def} !== 19'h00001) begin
      errors++; $display("FAIL reset_abc got %h want 00001", {a_def, b_def, cmd_def});
    end
    checks++;
    if ({busy_def, done_def, pass_def, sig_def} !== 11'h000) begin
      errors++; $display("FAIL reset_flags busy %b done %b pass %b sig %h want 0 0 0 00",
                         busy_def, done_def, pass_def, sig_def);
    end
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_sequence;
    logic [18:0] l;
    int cyc;
    start_def = 1'b1;
    tick;
    start_def = 1'b0;
    checks++;
    if (cmd_def !== 3'd1 || busy_def !== 1'b1) begin
      errors++; $display("FAIL seq_first cmd %0d busy %b want 1 1", cmd_def, busy_def);
    end
    tick;
    checks++;
    if (cmd_def !== 3'd2) begin errors++; $display("FAIL seq_cmd2 got %0d want 2", cmd_def); end
    tick;
    checks++;
    if (cmd_def !== 3'd4) begin errors++; $display("FAIL seq_cmd4 got %0d want 4", cmd_def); end
    tick;
    checks++;
    if (b_def !== 8'h01 || cmd_def !== 3'd0) begin
      errors++; $display("FAIL seq_b01 b %h cmd %0d want 01 0", b_def, cmd_def);
    end
    l = 19'h00008;
    for (int k = 4; k < 40; k++) begin
      tick;
      l = {l[17:0], l[18] ^ l[17] ^ l[16] ^ l[13]};
      checks++;
      if ({a_def, b_def, cmd_def} !== l) begin
        errors++; $display("FAIL seq_k%0d got %h want %h", k, {a_def, b_def, cmd_def}, l);
      end
    end
    cyc = 0;
    while (done_def !== 1'b1 && cyc < 400) begin tick; cyc++; end
    checks++;
    if (done_def !== 1'b1) begin errors++; $display("FAIL seq_timeout done %b want 1", done_def); end
  endtask

  task automatic test_full_run;
    int cyc;
    int both;
    start_def = 1'b1;
    tick;
    start_def = 1'b0;
    checks++;
    if (pass_def !== 1'b0) begin errors++; $display("FAIL run_pass_clr got %b want 0", pass_def); end
    cyc = 0;
    both = 0;
    while (done_def !== 1'b1 && cyc < 400) begin
      if (busy_def === 1'b1) cyc++;
      if (busy_def === 1'b1 && done_def === 1'b1) both++;
      tick;
    end
    checks++;
    if (cyc != 255) begin errors++; $display("FAIL run_busy_len got %0d want 255", cyc); end
    checks++;
    if (both != 0) begin errors++; $display("FAIL run_busy_done_overlap got %0d want 0", both); end
    checks++;
    if ({done_def, busy_def, pass_def, sig_def} !== 11'h500) begin
      errors++; $display("FAIL run_end done %b busy %b pass %b sig %h want 1 0 1 00",
                         done_def, busy_def, pass_def, sig_def);
    end
    repeat (5) tick;
    checks++;
    if ({done_def, pass_def, sig_def} !== 10'h300) begin
      errors++; $display("FAIL run_hold done %b pass %b sig %h want 1 1 00",
                         done_def, pass_def, sig_def);
    end
  endtask

  task automatic test_start_in_run;
    int e;
    start_def = 1'b1;
    tick;
    start_def = 1'b0;
    e = 0;
    while (done_def !== 1'b1 && e < 400) begin
      tick;
      e++;
      if (e == 10) start_def = 1'b1;
      if (e == 11) start_def = 1'b0;
    end
    checks++;
    if (e != 255) begin errors++; $display("FAIL start_in_run done_edge got %0d want 255", e); end
  endtask

  task automatic test_rst_mid_run;
    logic [18:0] l;
    int e;
    int seen;
    start_def = 1'b1;
    tick;
    start_def = 1'b0;
    for (e = 0; e < 100; e++) tick;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_def, b_def, cmd_def} !== 19'h00001 || sig_def !== 8'h00) begin
      errors++; $display("FAIL rst_mid_abc_sig got %h %h want 00001 00",
                         {a_def, b_def, cmd_def}, sig_def);
    end
    checks++;
    if ({busy_def, done_def, pass_def} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_flags got %b want 000", {busy_def, done_def, pass_def});
    end
    tick;
    rst = 1'b0;
    seen = 0;
    repeat (300) begin tick; if (done_def !== 1'b0 || busy_def !== 1'b0) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d want 0", seen); end
    start_def = 1'b1;
    tick;
    start_def = 1'b0;
    l = 19'h00001;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if ({a_def, b_def, cmd_def} !== l) seen++;
      l = {l[17:0], l[18] ^ l[17] ^ l[16] ^ l[13]};
      tick;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_mid_restart_seq got %0d want 0", seen); end
    e = 0;
    while (done_def !== 1'b1 && e < 400) begin tick; e++; end
    checks++;
    if (done_def !== 1'b1 || sig_def !== 8'h00) begin
      errors++; $display("FAIL rst_mid_rerun done %b sig %h want 1 00", done_def, sig_def);
    end
  endtask

  task automatic test_n2;
    start_n2 = 1'b1;
    tick;
    start_n2 = 1'b0;
    checks++;
    if (busy_n2a !== 1'b1 || done_n2a !== 1'b0) begin
      errors++; $display("FAIL n2_busy busy %b done %b want 1 0", busy_n2a, done_n2a);
    end
    tick;
    tick;
    checks++;
    if (done_n2a !== 1'b1 || sig_n2a !== 8'h03 || pass_n2a !== 1'b1) begin
      errors++; $display("FAIL n2_gold03 done %b sig %h pass %b want 1 03 1",
                         done_n2a, sig_n2a, pass_n2a);
    end
    checks++;
    if (done_n2b !== 1'b1 || busy_n2b !== 1'b0 || sig_n2b !== 8'h03 || pass_n2b !== 1'b0) begin
      errors++; $display("FAIL n2_gold00 done %b busy %b sig %h pass %b want 1 0 03 0",
                         done_n2b, busy_n2b, sig_n2b, pass_n2b);
    end
    checks++;
    if ({a_n2a, b_n2a, cmd_n2a} !== 19'h00001 || {a_n2b, b_n2b, cmd_n2b} !== 19'h00001) begin
      errors++; $display("FAIL n2_seed_reload got %h %h want 00001 00001",
                         {a_n2a, b_n2a, cmd_n2a}, {a_n2b, b_n2b, cmd_n2b});
    end
  endtask

  task automatic test_alu;
    int cyc;
    start_alu = 1'b1;
    tick;
    start_alu = 1'b0;
    cyc = 0;
    while (done_alu !== 1'b1 && cyc < 400) begin tick; cyc++; end
    checks++;
    if (pass_alu !== 1'b1 || sig_alu !== GOLD_ALU) begin
      errors++; $display("FAIL alu_pass pass %b sig %h want 1 %h", pass_alu, sig_alu, GOLD_ALU);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    start_alu = 1'b1;
    tick;
    start_alu = 1'b0;
    checks++;
    if (pass_alu !== 1'b0 || busy_alu !== 1'b1 || done_alu !== 1'b0) begin
      errors++; $display("FAIL b2b_restart pass %b busy %b done %b want 0 1 0",
                         pass_alu, busy_alu, done_alu);
    end
    cyc = 0;
    while (done_alu !== 1'b1 && cyc < 400) begin tick; cyc++; end
    checks++;
    if (pass_alu !== 1'b1 || sig_alu !== GOLD_ALU) begin
      errors++; $display("FAIL b2b_sig pass %b sig %h want 1 %h", pass_alu, sig_alu, GOLD_ALU);
    end
  endtask

  task automatic test_stuck;
    int cyc;
    fault = 1'b1;
    start_alu = 1'b1;
    tick;
    start_alu = 1'b0;
    cyc = 0;
    while (done_alu !== 1'b1 && cyc < 400) begin tick; cyc++; end
    checks++;
    if (pass_alu !== 1'b0 || sig_alu === GOLD_ALU) begin
      errors++; $display("FAIL stuck_detect pass %b sig %h want 0 and sig not %h",
                         pass_alu, sig_alu, GOLD_ALU);
    end
    checks++;
    if (sig_alu !== GOLD_STUCK) begin
      errors++; $display("FAIL stuck_sig got %h want %h", sig_alu, GOLD_STUCK);
    end
    fault = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sequence;
    test_full_run;
    test_start_in_run;
    test_rst_mid_run;
    test_n2;
    test_alu;
    test_back_to_back;
    test_stuck;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
